aes_bram_arbiter: RTL and testbench

//  Shares one 32-bit BRAM port between two AES_TOP-style requesters (r0, r1).

---
 rtl/aes_bram_arbiter.sv | 121 ++++++++++++
 tb/tb_aes_bram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two AES requesters.
// One access in flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> HOLDOFF -> IDLE.
`timescale 1ns/1ps
module aes_bram_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              aes_clk,
  input  logic              aes_rst_n,
  input  logic              r0_start_read,
  input  logic              r0_start_write,
  input  logic [ADDR_W-1:0] r0_bram_addr,
  input  logic [ADDR_W-1:0] r0_bram_write_addr,
  input  logic [31:0]       r0_bram_write_data,
  output logic [31:0]       r0_bram_read_data,
  output logic              r0_bram_complete,
  input  logic              r1_start_read,
  input  logic              r1_start_write,
  input  logic [ADDR_W-1:0] r1_bram_addr,
  input  logic [ADDR_W-1:0] r1_bram_write_addr,
  input  logic [31:0]       r1_bram_write_data,
  output logic [31:0]       r1_bram_read_data,
  output logic              r1_bram_complete,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              arb_busy,
  output logic              arb_last_grant
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLDOFF} state_t;

  state_t            state;
  logic              gnt;
  logic              op_wr;
  logic              rr_ptr;
  logic [2:0]        cnt;
  logic              req0, req1, sel, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Write wins when a requester raises both levels; rr_ptr names who goes first on a tie.
  always_comb begin
    req0      = r0_start_read | r0_start_write;
    req1      = r1_start_read | r1_start_write;
    sel       = (req0 && req1) ? rr_ptr : req1;
    sel_wr    = sel ? r1_start_write : r0_start_write;
    sel_wdata = sel ? r1_bram_write_data : r0_bram_write_data;
    if (sel)
      sel_addr = r1_start_write ? r1_bram_write_addr : r1_bram_addr;
    else
      sel_addr = r0_start_write ? r0_bram_write_addr : r0_bram_addr;
  end

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state             <= IDLE;
      gnt               <= 1'b0;
      op_wr             <= 1'b0;
      rr_ptr            <= 1'b0;
      cnt               <= '0;
      r0_bram_read_data <= '0;
      r1_bram_read_data <= '0;
      r0_bram_complete  <= 1'b0;
      r1_bram_complete  <= 1'b0;
      bram_en           <= 1'b0;
      bram_we           <= '0;
      bram_addr         <= '0;
      bram_wdata        <= '0;
      arb_busy          <= 1'b0;
      arb_last_grant    <= 1'b0;
    end else begin
      bram_en          <= 1'b0;
      bram_we          <= '0;
      r0_bram_complete <= 1'b0;
      r1_bram_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt            <= sel;
            arb_last_grant <= sel;
            rr_ptr         <= ~sel;
            op_wr          <= sel_wr;
            bram_en        <= 1'b1;
            bram_we        <= sel_wr ? 4'hF : 4'h0;
            bram_addr      <= sel_addr;
            bram_wdata     <= sel_wdata;
            arb_busy       <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= op_wr ? 3'd0 : 3'(RD_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (!op_wr) begin
              if (gnt) r1_bram_read_data <= bram_rdata;
              else     r0_bram_read_data <= bram_rdata;
            end
            r0_bram_complete <= ~gnt;
            r1_bram_complete <= gnt;
            state            <= DONE;
          end else begin
            cnt <= 3'(cnt - 3'd1);
          end
        end
        DONE: state <= HOLDOFF;
        HOLDOFF: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bram_arbiter.sv
// Directed bench for aes_bram_arbiter with a 2-cycle-latency BRAM model.
`timescale 1ns/1ps
module tb_aes_bram_arbiter;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        aes_clk = 1'b0;
  logic        aes_rst_n = 1'b0;
  logic        r0_start_read = 1'b0, r0_start_write = 1'b0;
  logic [31:0] r0_bram_addr = '0, r0_bram_write_addr = '0, r0_bram_write_data = '0;
  logic [31:0] r0_bram_read_data;
  logic        r0_bram_complete;
  logic        r1_start_read = 1'b0, r1_start_write = 1'b0;
  logic [31:0] r1_bram_addr = '0, r1_bram_write_addr = '0, r1_bram_write_data = '0;
  logic [31:0] r1_bram_read_data;
  logic        r1_bram_complete;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_wdata;
  logic [31:0] bram_rdata = '0;
  logic        arb_busy, arb_last_grant;

  int vectors = 0;
  int miscompares = 0;

  aes_bram_arbiter #(.RD_LATENCY(2), .ADDR_W(32)) dut (
    .aes_clk(aes_clk), .aes_rst_n(aes_rst_n),
    .r0_start_read(r0_start_read), .r0_start_write(r0_start_write),
    .r0_bram_addr(r0_bram_addr), .r0_bram_write_addr(r0_bram_write_addr),
    .r0_bram_write_data(r0_bram_write_data), .r0_bram_read_data(r0_bram_read_data),
    .r0_bram_complete(r0_bram_complete),
    .r1_start_read(r1_start_read), .r1_start_write(r1_start_write),
    .r1_bram_addr(r1_bram_addr), .r1_bram_write_addr(r1_bram_write_addr),
    .r1_bram_write_data(r1_bram_write_data), .r1_bram_read_data(r1_bram_read_data),
    .r1_bram_complete(r1_bram_complete),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .arb_busy(arb_busy), .arb_last_grant(arb_last_grant)
  );

  always #5 aes_clk = ~aes_clk;

  // BRAM model: unwritten words read back as addr ^ PAT, two-cycle read latency.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pipe1 = '0;
  always @(posedge aes_clk) begin
    if (bram_en && bram_we == 4'hF) mem[bram_addr] = bram_wdata;
    if (bram_en && bram_we == 4'h0)
      pipe1 <= mem.exists(bram_addr) ? mem[bram_addr] : (bram_addr ^ PAT);
    bram_rdata <= pipe1;
  end

  int cyc = 0;
  always @(posedge aes_clk) cyc++;

  // Access log and complete-pulse monitor.
  logic [31:0] addr_q[$], wdata_q[$];
  logic [3:0]  we_q[$];
  logic        grant_q[$];
  int          en_cyc_q[$];
  int          c0 = 0, c1 = 0, long_pulses = 0;
  logic        p0 = 1'b0, p1 = 1'b0;
  always @(negedge aes_clk) begin
    if (bram_en) begin
      addr_q.push_back(bram_addr);
      wdata_q.push_back(bram_wdata);
      we_q.push_back(bram_we);
      grant_q.push_back(arb_last_grant);
      en_cyc_q.push_back(cyc);
    end
    if (r0_bram_complete) c0++;
    if (r1_bram_complete) c1++;
    if ((r0_bram_complete && p0) || (r1_bram_complete && p1)) long_pulses++;
    p0 = r0_bram_complete;
    p1 = r1_bram_complete;
  end

  task automatic wait_cmp(input int idx, input int budget, output int lat);
    lat = -1;
    for (int n = 0; n <= budget; n++) begin
      @(negedge aes_clk);
      if ((idx == 0) ? r0_bram_complete : r1_bram_complete) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aes_clk);
    aes_rst_n = 1'b0;
    repeat (2) @(posedge aes_clk);
    @(negedge aes_clk);
    aes_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    aes_rst_n = 1'b0;
    repeat (2) @(posedge aes_clk);
    @(negedge aes_clk);
    vectors++;
    if ({bram_en, bram_we, bram_addr, bram_wdata} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_bram: got en=%b we=%h addr=%h wdata=%h want all 0", bram_en, bram_we, bram_addr, bram_wdata);
    end
    vectors++;
    if ({r0_bram_read_data, r1_bram_read_data, r0_bram_complete, r1_bram_complete, arb_busy, arb_last_grant} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_req: got rd0=%h rd1=%h c0=%b c1=%b busy=%b lg=%b want all 0",
               r0_bram_read_data, r1_bram_read_data, r0_bram_complete, r1_bram_complete, arb_busy, arb_last_grant);
    end
    aes_rst_n = 1'b1;
  endtask

  task automatic test_read_r0();
    int lat;
    int base = addr_q.size();
    @(posedge aes_clk); #1;
    r0_start_read = 1'b1; r0_bram_addr = 32'h10;
    wait_cmp(0, 20, lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL read_latency: got %0d want 4", lat); end
    vectors++;
    if (r0_bram_read_data !== 32'hA5A5_0010) begin
      miscompares++; $display("FAIL read_data: got %h want a5a50010", r0_bram_read_data);
    end
    @(posedge aes_clk); #1;
    r0_start_read = 1'b0;
    repeat (4) @(posedge aes_clk);
    vectors++;
    if (addr_q.size() - base !== 1) begin
      miscompares++; $display("FAIL read_en_count: got %0d want 1", addr_q.size() - base);
    end
    vectors++;
    if ({addr_q[base], we_q[base]} !== {32'h10, 4'h0}) begin
      miscompares++; $display("FAIL read_issue: got addr=%h we=%h want 10/0", addr_q[base], we_q[base]);
    end
  endtask

  task automatic test_write_r1();
    int lat;
    int base = addr_q.size();
    @(posedge aes_clk); #1;
    r1_start_write = 1'b1; r1_bram_write_addr = 32'h20; r1_bram_write_data = 32'hDEAD_BEEF;
    wait_cmp(1, 20, lat);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL write_latency: got %0d want 3", lat); end
    vectors++;
    if (r1_bram_read_data !== 32'h0) begin
      miscompares++; $display("FAIL write_keeps_rdata: got %h want 0", r1_bram_read_data);
    end
    @(posedge aes_clk); #1;
    r1_start_write = 1'b0;
    repeat (4) @(posedge aes_clk);
    vectors++;
    if ({addr_q[base], we_q[base], wdata_q[base]} !== {32'h20, 4'hF, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL write_issue: got addr=%h we=%h wdata=%h want 20/f/deadbeef", addr_q[base], we_q[base], wdata_q[base]);
    end
  endtask

  task automatic test_simultaneous();
    int t0 = -1, t1 = -1;
    logic d0, d1;
    int base;
    do_reset();
    base = grant_q.size();
    @(posedge aes_clk); #1;
    r0_start_read = 1'b1; r0_bram_addr = 32'h30;
    r1_start_read = 1'b1; r1_bram_addr = 32'h40;
    for (int n = 0; n < 24; n++) begin
      @(negedge aes_clk);
      d0 = r0_bram_complete; d1 = r1_bram_complete;
      if (d0) t0 = n;
      if (d1) t1 = n;
      @(posedge aes_clk); #1;
      if (d0) r0_start_read = 1'b0;
      if (d1) r1_start_read = 1'b0;
    end
    vectors++;
    if (t0 !== 4 || t1 !== 10) begin
      miscompares++; $display("FAIL sim_timing: got t0=%0d t1=%0d want 4/10", t0, t1);
    end
    vectors++;
    if (grant_q.size() - base !== 2 || {grant_q[base], grant_q[base+1]} !== 2'b01) begin
      miscompares++; $display("FAIL sim_grant_order: got n=%0d g=%b%b want 2 grants 0,1",
                              grant_q.size() - base, grant_q[base], grant_q[base+1]);
    end
    vectors++;
    if ({r0_bram_read_data, r1_bram_read_data} !== {32'hA5A5_0030, 32'hA5A5_0040}) begin
      miscompares++; $display("FAIL sim_rdata: got %h %h want a5a50030 a5a50040", r0_bram_read_data, r1_bram_read_data);
    end
  endtask

  task automatic test_back_to_back();
    int base = grant_q.size();
    int b0 = c0, b1 = c1, bl = long_pulses;
    @(posedge aes_clk); #1;
    r0_start_read = 1'b1; r0_bram_addr = 32'h50;
    r1_start_read = 1'b1; r1_bram_addr = 32'h60;
    for (int n = 0; n < 40; n++) begin
      @(posedge aes_clk);
      if (grant_q.size() - base >= 4) break;
    end
    #1;
    r0_start_read = 1'b0; r1_start_read = 1'b0;
    repeat (10) @(posedge aes_clk);
    vectors++;
    if (grant_q.size() - base !== 4 ||
        {grant_q[base], grant_q[base+1], grant_q[base+2], grant_q[base+3]} !== 4'b0101) begin
      miscompares++; $display("FAIL b2b_grants: got n=%0d g=%b%b%b%b want 0101", grant_q.size() - base,
                              grant_q[base], grant_q[base+1], grant_q[base+2], grant_q[base+3]);
    end
    vectors++;
    if ({addr_q[base], addr_q[base+1], addr_q[base+2], addr_q[base+3]} !==
        {32'h50, 32'h60, 32'h50, 32'h60}) begin
      miscompares++; $display("FAIL b2b_addr: got %h %h %h %h want 50 60 50 60",
                              addr_q[base], addr_q[base+1], addr_q[base+2], addr_q[base+3]);
    end
    vectors++;
    if (en_cyc_q[base+1] - en_cyc_q[base] !== 6) begin
      miscompares++; $display("FAIL b2b_spacing: got %0d want 6", en_cyc_q[base+1] - en_cyc_q[base]);
    end
    vectors++;
    if (c0 - b0 !== 2 || c1 - b1 !== 2 || long_pulses - bl !== 0) begin
      miscompares++; $display("FAIL b2b_pulses: got c0=%0d c1=%0d long=%0d want 2/2/0", c0 - b0, c1 - b1, long_pulses - bl);
    end
    vectors++;
    if ({r0_bram_read_data, r1_bram_read_data} !== {32'hA5A5_0050, 32'hA5A5_0060}) begin
      miscompares++; $display("FAIL b2b_rdata: got %h %h want a5a50050 a5a50060", r0_bram_read_data, r1_bram_read_data);
    end
  endtask

  task automatic test_write_priority();
    int lat;
    int base = addr_q.size();
    @(posedge aes_clk); #1;
    r0_start_read = 1'b1; r0_start_write = 1'b1;
    r0_bram_addr = 32'h70; r0_bram_write_addr = 32'h74; r0_bram_write_data = 32'h1234_5678;
    wait_cmp(0, 20, lat);
    vectors++;
    if (lat !== 3 || r0_bram_read_data !== 32'hA5A5_0050) begin
      miscompares++; $display("FAIL prio_write: got lat=%0d rd=%h want 3/a5a50050", lat, r0_bram_read_data);
    end
    @(posedge aes_clk); #1;
    r0_start_write = 1'b0;
    wait_cmp(0, 20, lat);
    vectors++;
    if (lat !== 5 || r0_bram_read_data !== 32'hA5A5_0070) begin
      miscompares++; $display("FAIL prio_read: got lat=%0d rd=%h want 5/a5a50070", lat, r0_bram_read_data);
    end
    @(posedge aes_clk); #1;
    r0_start_read = 1'b0;
    repeat (3) @(posedge aes_clk);
    vectors++;
    if ({addr_q[base], we_q[base], wdata_q[base], addr_q[base+1], we_q[base+1]} !==
        {32'h74, 4'hF, 32'h1234_5678, 32'h70, 4'h0}) begin
      miscompares++; $display("FAIL prio_order: got %h/%h/%h then %h/%h want 74/f/12345678 then 70/0",
                              addr_q[base], we_q[base], wdata_q[base], addr_q[base+1], we_q[base+1]);
    end
    // Read level withdrawn during the write: only the write is served.
    @(posedge aes_clk); #1;
    r0_start_read = 1'b1; r0_start_write = 1'b1;
    r0_bram_addr = 32'h7C; r0_bram_write_addr = 32'h78; r0_bram_write_data = 32'hCAFE_F00D;
    wait_cmp(0, 20, lat);
    @(posedge aes_clk); #1;
    r0_start_read = 1'b0; r0_start_write = 1'b0;
    repeat (10) @(posedge aes_clk);
    vectors++;
    if (addr_q.size() - base !== 3 || addr_q[base+2] !== 32'h78) begin
      miscompares++; $display("FAIL prio_dropped_read: got n=%0d addr=%h want 3/78", addr_q.size() - base, addr_q[base+2]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int b1;
    @(posedge aes_clk); #1;
    r1_start_read = 1'b1; r1_bram_addr = 32'h80;
    repeat (3) @(negedge aes_clk);
    vectors++;
    if (arb_busy !== 1'b1 || bram_en !== 1'b0) begin
      miscompares++; $display("FAIL mid_wait_state: got busy=%b en=%b want 1/0", arb_busy, bram_en);
    end
    b1 = c1;
    #1;
    aes_rst_n = 1'b0;
    r1_start_read = 1'b0;
    #1;
    vectors++;
    if ({arb_busy, bram_en, r1_bram_complete, arb_last_grant, r1_bram_read_data} !== 36'd0) begin
      miscompares++; $display("FAIL mid_reset_outputs: got busy=%b en=%b c1=%b lg=%b rd1=%h want all 0",
                              arb_busy, bram_en, r1_bram_complete, arb_last_grant, r1_bram_read_data);
    end
    repeat (3) @(posedge aes_clk);
    @(negedge aes_clk);
    aes_rst_n = 1'b1;
    repeat (4) @(posedge aes_clk);
    vectors++;
    if (c1 - b1 !== 0) begin
      miscompares++; $display("FAIL mid_no_complete: got %0d pulses want 0", c1 - b1);
    end
    #1;
    r1_start_read = 1'b1; r1_bram_addr = 32'h20;
    wait_cmp(1, 20, lat);
    vectors++;
    if (lat !== 4 || r1_bram_read_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL mid_recover: got lat=%0d rd=%h want 4/deadbeef", lat, r1_bram_read_data);
    end
    @(posedge aes_clk); #1;
    r1_start_read = 1'b0;
    repeat (3) @(posedge aes_clk);
  endtask

  initial begin
    test_reset();
    test_read_r0();
    test_write_r1();
    test_simultaneous();
    test_back_to_back();
    test_write_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
